// File: rtl/fp_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fp_operand_sequencer
// Description : Loads two FP_W-bit operands and a control word chunk by chunk
//               from the switch bank, runs a start/done handshake with the FP
//               ALU and pages the result and flags out to the display.
//               Optional ALU watchdog: define FP_SEQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_operand_sequencer #(
    parameter int SW_W        = 16,
    parameter int FP_W        = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic            clk_w,
    input  logic            reset,
    input  logic            btn_next,
    input  logic [SW_W-1:0] sw,
    input  logic            alu_done,
    input  logic [FP_W-1:0] alu_result,
    input  logic [4:0]      alu_flags,
    output logic [FP_W-1:0] opa,
    output logic [FP_W-1:0] opb,
    output logic [1:0]      op_code,
    output logic            round_mode,
    output logic            alu_start,
    output logic            busy,
    output logic [SW_W-1:0] shown,
    output logic [4:0]      flags_out,
    output logic            err
);

    localparam int NCHUNK = FP_W / SW_W;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [CW-1:0]   c_IDX_TOP  = CW'(NCHUNK - 1);
    localparam logic [SW_W-1:0] c_FPW_DISP = SW_W'(FP_W);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD_A    = 3'd1;
    localparam logic [2:0] S_LOAD_B    = 3'd2;
    localparam logic [2:0] S_LOAD_CTRL = 3'd3;
    localparam logic [2:0] S_ISSUE     = 3'd4;
    localparam logic [2:0] S_WAIT      = 3'd5;
    localparam logic [2:0] S_SHOW_RES  = 3'd6;
    localparam logic [2:0] S_SHOW_FLG  = 3'd7;

    generate
        if (((FP_W % SW_W) != 0) || (FP_W < SW_W) || (SW_W < 5) || (TIMEOUT_CYC < 1)) begin : g_param_check
            $error("fp_operand_sequencer: illegal SW_W/FP_W/TIMEOUT_CYC combination");
        end
    endgenerate

    logic [2:0]      r_state;
    logic [CW-1:0]   r_idx;
    logic [FP_W-1:0] r_opa;
    logic [FP_W-1:0] r_opb;
    logic [1:0]      r_op_code;
    logic            r_round_mode;
    logic [FP_W-1:0] r_res;
    logic [4:0]      r_flg;
    logic            r_alu_start;
    logic [SW_W-1:0] w_shown;

`ifdef FP_SEQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] c_TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] r_tmo_cnt;
    logic          r_err;
`endif

    always_ff @(posedge clk_w) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_idx        <= c_IDX_TOP;
            r_opa        <= '0;
            r_opb        <= '0;
            r_op_code    <= 2'b00;
            r_round_mode <= 1'b0;
            r_res        <= '0;
            r_flg        <= 5'b0;
            r_alu_start  <= 1'b0;
`ifdef FP_SEQ_TIMEOUT_EN
            r_tmo_cnt    <= '0;
            r_err        <= 1'b0;
`endif
        end else begin
            r_alu_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (btn_next) begin
                        r_state <= S_LOAD_A;
                        r_idx   <= c_IDX_TOP;
`ifdef FP_SEQ_TIMEOUT_EN
                        r_err   <= 1'b0;
`endif
                    end
                end
                S_LOAD_A: begin
                    if (btn_next) begin
                        r_opa[int'(r_idx)*SW_W +: SW_W] <= sw;
                        if (r_idx == '0) begin
                            r_state <= S_LOAD_B;
                            r_idx   <= c_IDX_TOP;
                        end else begin
                            r_idx <= r_idx - CW'(1);
                        end
                    end
                end
                S_LOAD_B: begin
                    if (btn_next) begin
                        r_opb[int'(r_idx)*SW_W +: SW_W] <= sw;
                        if (r_idx == '0) begin
                            r_state <= S_LOAD_CTRL;
                        end else begin
                            r_idx <= r_idx - CW'(1);
                        end
                    end
                end
                S_LOAD_CTRL: begin
                    if (btn_next) begin
                        r_op_code    <= sw[1:0];
                        r_round_mode <= sw[2];
                        r_state      <= S_ISSUE;
                        // Registered so the pulse lines up exactly with ISSUE.
                        r_alu_start  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
`ifdef FP_SEQ_TIMEOUT_EN
                    r_tmo_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (alu_done) begin
                        r_res   <= alu_result;
                        r_flg   <= alu_flags;
                        r_state <= S_SHOW_RES;
                        r_idx   <= c_IDX_TOP;
                    end
`ifdef FP_SEQ_TIMEOUT_EN
                    else if (r_tmo_cnt == c_TMO_LAST) begin
                        r_res   <= '1;
                        r_flg   <= 5'b11111;
                        r_err   <= 1'b1;
                        r_state <= S_SHOW_RES;
                        r_idx   <= c_IDX_TOP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TW'(1);
                    end
`endif
                end
                S_SHOW_RES: begin
                    if (btn_next) begin
                        if (r_idx == '0) begin
                            r_state <= S_SHOW_FLG;
                        end else begin
                            r_idx <= r_idx - CW'(1);
                        end
                    end
                end
                S_SHOW_FLG: begin
                    if (btn_next) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_shown = '0;
        case (r_state)
            S_IDLE:                          w_shown = c_FPW_DISP;
            S_LOAD_A, S_LOAD_B, S_LOAD_CTRL: w_shown = sw;
            S_SHOW_RES:                      w_shown = r_res[int'(r_idx)*SW_W +: SW_W];
            S_SHOW_FLG:                      w_shown = SW_W'(r_flg);
            default:                         w_shown = '0;
        endcase
    end

    assign opa        = r_opa;
    assign opb        = r_opb;
    assign op_code    = r_op_code;
    assign round_mode = r_round_mode;
    assign alu_start  = r_alu_start;
    assign busy       = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign shown      = w_shown;
    assign flags_out  = ((r_state == S_SHOW_RES) || (r_state == S_SHOW_FLG)) ? r_flg : 5'b0;

`ifdef FP_SEQ_TIMEOUT_EN
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_operand_sequencer.sv
`default_nettype none
// Bench for fp_operand_sequencer: transaction-level model for the 32-bit build
// checked every cycle, plus directed literal checks on 32- and 16-bit builds.
module tb_fp_operand_sequencer;

    localparam int N   = 2;
    localparam int TMO = 8;

    logic        clk_w = 1'b0;
    logic        reset;
    logic        btn_next;
    logic [15:0] sw;
    logic        alu_done;
    logic [31:0] alu_result;
    logic [4:0]  alu_flags;
    logic [31:0] opa, opb;
    logic [1:0]  op_code;
    logic        round_mode, alu_start, busy, err;
    logic [15:0] shown;
    logic [4:0]  flags_out;

    logic        btn16;
    logic [15:0] sw16;
    logic        done16;
    logic [15:0] res16;
    logic [4:0]  flg16;
    logic [15:0] opa16, opb16, shown16;
    logic [1:0]  op_code16;
    logic        round16, start16, busy16, err16;
    logic [4:0]  flags_out16;

    int checks   = 0;
    int failures = 0;

    always #5 clk_w = ~clk_w;

    fp_operand_sequencer #(.SW_W(16), .FP_W(32), .TIMEOUT_CYC(TMO)) dut (
        .clk_w(clk_w), .reset(reset), .btn_next(btn_next), .sw(sw),
        .alu_done(alu_done), .alu_result(alu_result), .alu_flags(alu_flags),
        .opa(opa), .opb(opb), .op_code(op_code), .round_mode(round_mode),
        .alu_start(alu_start), .busy(busy), .shown(shown),
        .flags_out(flags_out), .err(err)
    );

    fp_operand_sequencer #(.SW_W(16), .FP_W(16), .TIMEOUT_CYC(TMO)) dut16 (
        .clk_w(clk_w), .reset(reset), .btn_next(btn16), .sw(sw16),
        .alu_done(done16), .alu_result(res16), .alu_flags(flg16),
        .opa(opa16), .opb(opb16), .op_code(op_code16), .round_mode(round16),
        .alu_start(start16), .busy(busy16), .shown(shown16),
        .flags_out(flags_out16), .err(err16)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 entry, 2 issue, 3 wait, 4 show; m_cnt = buttons taken in phase.
    int          m_phase, m_cnt, m_wait;
    logic [31:0] m_opa, m_opb, m_res;
    logic [1:0]  m_op;
    logic        m_rm, m_err;
    logic [4:0]  m_flg;
    bit          m_valid = 0;

    always @(posedge clk_w) begin
        if (reset) begin
            m_phase <= 0; m_cnt <= 0; m_wait <= 0;
            m_opa <= '0; m_opb <= '0; m_res <= '0; m_op <= '0;
            m_rm <= 1'b0; m_flg <= '0; m_err <= 1'b0; m_valid <= 1;
        end else begin
            case (m_phase)
                0: if (btn_next) begin m_phase <= 1; m_cnt <= 0; m_err <= 1'b0; end
                1: if (btn_next) begin
                    if (m_cnt < N) m_opa[(N-1-m_cnt)*16 +: 16] <= sw;
                    else if (m_cnt < 2*N) m_opb[(2*N-1-m_cnt)*16 +: 16] <= sw;
                    else begin m_op <= sw[1:0]; m_rm <= sw[2]; m_phase <= 2; end
                    m_cnt <= m_cnt + 1;
                end
                2: begin m_phase <= 3; m_wait <= 0; end
                3: begin
                    if (alu_done) begin
                        m_res <= alu_result; m_flg <= alu_flags; m_phase <= 4; m_cnt <= 0;
                    end
`ifdef FP_SEQ_TIMEOUT_EN
                    else if (m_wait + 1 == TMO) begin
                        m_res <= 32'hFFFF_FFFF; m_flg <= 5'h1F; m_err <= 1'b1;
                        m_phase <= 4; m_cnt <= 0;
                    end else m_wait <= m_wait + 1;
`endif
                end
                default: if (btn_next) begin
                    if (m_cnt == N) m_phase <= 0;
                    else m_cnt <= m_cnt + 1;
                end
            endcase
        end
    end

    function automatic logic [15:0] exp_shown();
        case (m_phase)
            0:       return 16'd32;
            1:       return sw;
            4:       return (m_cnt < N) ? m_res[(N-1-m_cnt)*16 +: 16] : {11'b0, m_flg};
            default: return 16'h0000;
        endcase
    endfunction

    always @(negedge clk_w) begin
        if (m_valid) begin
            chk("opa", opa, m_opa);
            chk("opb", opb, m_opb);
            chk("op_code", op_code, m_op);
            chk("round_mode", round_mode, m_rm);
            chk("alu_start", alu_start, m_phase == 2);
            chk("busy", busy, (m_phase == 2) || (m_phase == 3));
            chk("shown", shown, exp_shown());
            chk("flags_out", flags_out, (m_phase == 4) ? m_flg : 5'b0);
            chk("err", err, m_err);
        end
    end

    task automatic tick();
        @(posedge clk_w);
        #1;
    endtask

    task automatic press(input logic [15:0] v);
        sw = v; btn_next = 1'b1;
        tick();
        btn_next = 1'b0;
    endtask

    task automatic press16(input logic [15:0] v);
        sw16 = v; btn16 = 1'b1;
        tick();
        btn16 = 1'b0;
    endtask

    task automatic alu_reply(input int dly, input logic [31:0] r, input logic [4:0] f);
        repeat (dly) tick();
        alu_done = 1'b1; alu_result = r; alu_flags = f;
        tick();
        alu_done = 1'b0;
    endtask

    // Full operand/control entry from IDLE, ending in ISSUE.
    task automatic enter_op(input logic [31:0] a, input logic [31:0] b, input logic [15:0] c);
        press(16'h1111);
        press(a[31:16]); press(a[15:0]);
        press(b[31:16]); press(b[15:0]);
        press(c);
    endtask

    initial begin
        reset = 1'b1; btn_next = 1'b0; sw = '0; alu_done = 1'b0; alu_result = '0; alu_flags = '0;
        btn16 = 1'b0; sw16 = '0; done16 = 1'b0; res16 = '0; flg16 = '0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("reset_shown", shown, 16'h0020);
        chk("reset_opa", opa, 32'h0);
        chk("reset_shown16", shown16, 16'h0010);

        // Basic operand load and handshake.
        enter_op(32'h3F80_0000, 32'h4000_0000, 16'h0000);
        chk("t1_opa", opa, 32'h3F80_0000);
        chk("t1_opb", opb, 32'h4000_0000);
        chk("t1_model_opa", m_opa, 32'h3F80_0000);
        chk("t1_start", alu_start, 1'b1);
        tick();
        chk("t1_start_off", alu_start, 1'b0);
        chk("t1_busy", busy, 1'b1);

        alu_reply(1, 32'h4040_0000, 5'b00001);
        chk("t2_hi", shown, 16'h4040);
        chk("t2_flags", flags_out, 5'b00001);
        press(16'h0);
        chk("t2_lo", shown, 16'h0000);
        press(16'h0);
        chk("t2_flg", shown, 16'h0001);
        press(16'h0);
        chk("t2_idle", shown, 16'h0020);
        chk("t2_idle_flags", flags_out, 5'b0);

        // alu_done outside WAIT is ignored.
        alu_done = 1'b1; alu_result = 32'hDEAD_BEEF; tick(); alu_done = 1'b0;
        chk("done_idle", shown, 16'h0020);

        // Buttons during WAIT, and one coincident with alu_done.
        enter_op(32'h1234_5678, 32'h9ABC_DEF0, 16'h0005);
        tick();
        press(16'h0); press(16'h0);
        chk("t4_busy", busy, 1'b1);
        btn_next = 1'b1; alu_done = 1'b1; alu_result = 32'hC000_0000; alu_flags = 5'b10100;
        tick();
        btn_next = 1'b0; alu_done = 1'b0;
        chk("t4_latched_hi", shown, 16'hC000);
        chk("t4_opcode", op_code, 2'd1);
        chk("t4_round", round_mode, 1'b1);
        press(16'h0); press(16'h0);
        chk("t4_flg", shown, 16'h0014);
        press(16'h0);

        // Reset while in LOAD_B at the last chunk.
        press(16'h0); press(16'hAAAA); press(16'hBBBB); press(16'hCCCC);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t5_opa", opa, 32'h0);
        chk("t5_shown", shown, 16'h0020);
        chk("t5_busy", busy, 1'b0);

        // Single-chunk build.
        press16(16'h0); press16(16'h1234); press16(16'h5678); press16(16'h0002);
        chk("t3_start16", start16, 1'b1);
        chk("t3_opa16", opa16, 16'h1234);
        chk("t3_opb16", opb16, 16'h5678);
        chk("t3_op16", op_code16, 2'd2);
        tick();
        done16 = 1'b1; res16 = 16'hABCD; flg16 = 5'b00101; tick(); done16 = 1'b0;
        chk("t3_res16", shown16, 16'hABCD);
        press16(16'h0);
        chk("t3_flg16", shown16, 16'h0005);
        chk("t3_flags16", flags_out16, 5'b00101);
        press16(16'h0);
        chk("t3_idle16", shown16, 16'h0010);
        chk("t3_busy16", busy16, 1'b0);

`ifdef FP_SEQ_TIMEOUT_EN
        enter_op(32'h1, 32'h2, 16'h0);
        tick();
        repeat (TMO - 1) tick();
        chk("t6_err_before", err, 1'b0);
        chk("t6_busy_before", busy, 1'b1);
        tick();
        chk("t6_err", err, 1'b1);
        chk("t6_shown", shown, 16'hFFFF);
        chk("t6_flags", flags_out, 5'b11111);
        press(16'h0); press(16'h0); press(16'h0);
        chk("t6_err_hold", err, 1'b1);
        press(16'h0);
        chk("t6_err_clr", err, 1'b0);
        press(16'h0); press(16'h0); press(16'h0); press(16'h0); press(16'h0);
        tick();
        repeat (TMO - 1) tick();
        alu_done = 1'b1; alu_result = 32'h3F80_0000; alu_flags = 5'b0;
        tick();
        alu_done = 1'b0;
        chk("t6_tie_err", err, 1'b0);
        chk("t6_tie_shown", shown, 16'h3F80);
`endif

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
